// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit with architectural Hi/Lo; stalls the pipeline while busy.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module ex_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] RegData1_i,
  input  logic [DATA_W-1:0] RegData2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              DivZero_o,
  output logic [DATA_W-1:0] Hi_o,
  output logic [DATA_W-1:0] Lo_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, stateNext;
  logic [1:0] opQ;
  logic signA, signB;
  logic [DATA_W-1:0] opB;
  logic [2*DATA_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic isSigned, isDiv, accept, divZero;
  logic [DATA_W-1:0] magA, magB;
  logic [DATA_W:0] mulSum, divShift, divDiff;
  logic [2*DATA_W-1:0] mulNext, divNext, accInit, prodFix;
  logic [DATA_W-1:0] quoFix, remFix, resHi, resLo;
  logic negRes;
  assign isSigned = ~op_i[0];
  assign isDiv    = op_i[1];
  assign magA     = (isSigned && RegData1_i[DATA_W-1]) ? -RegData1_i : RegData1_i;
  assign magB     = (isSigned && RegData2_i[DATA_W-1]) ? -RegData2_i : RegData2_i;
  assign accept   = (state == IDLE) && start_i && !flush_i;
  assign divZero  = isDiv && (RegData2_i == '0);
  // Multiply: multiplicand in opB, multiplier consumed LSB-first from the bottom of acc.
  assign mulSum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opB} : '0);
  assign mulNext  = {mulSum, acc[DATA_W-1:1]};
  // Divide: acc = {remainder, dividend/quotient}; quotient bits shift in from the right.
  assign divShift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign divDiff  = divShift - {1'b0, opB};
  assign divNext  = divDiff[DATA_W] ? {divShift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                    : {divDiff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  assign accInit = isDiv ? {{DATA_W{1'b0}}, magA}
                         : {{DATA_W{1'b0}}, magA} * {{DATA_W{1'b0}}, magB};
`else
  localparam bit FastMul = 1'b0;
  assign accInit = {{DATA_W{1'b0}}, isDiv ? magA : magB};
`endif
  assign negRes  = ~opQ[0] && (signA ^ signB);
  assign prodFix = negRes ? -acc : acc;
  assign quoFix  = negRes ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign remFix  = (~opQ[0] && signA) ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  assign resHi   = opQ[1] ? remFix : prodFix[2*DATA_W-1:DATA_W];
  assign resLo   = opQ[1] ? quoFix : prodFix[DATA_W-1:0];
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = divZero ? DONE : (FastMul && !isDiv) ? FIX : CALC;
      CALC: if (cnt == CNT_W'(DATA_W-1)) stateNext = FIX;
      FIX:  stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (flush_i) stateNext = IDLE;
  end
  assign stall_o = accept || (state == CALC) || (state == FIX);
  assign done_o  = (state == DONE);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      opQ       <= '0;
      signA     <= 1'b0;
      signB     <= 1'b0;
      opB       <= '0;
      acc       <= '0;
      cnt       <= '0;
      Hi_o      <= '0;
      Lo_o      <= '0;
      DivZero_o <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        opQ   <= op_i;
        signA <= isSigned && RegData1_i[DATA_W-1];
        signB <= isSigned && RegData2_i[DATA_W-1];
        opB   <= isDiv ? magB : magA;
        acc   <= accInit;
        cnt   <= '0;
      end
      if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= opQ[1] ? divNext : mulNext;
      end
      // Results land on the edge into DONE so they are visible while done_o is high.
      if (accept && divZero) begin
        Hi_o      <= RegData1_i;
        Lo_o      <= '1;
        DivZero_o <= 1'b1;
      end
      if (state == FIX && !flush_i) begin
        Hi_o      <= resHi;
        Lo_o      <= resLo;
        DivZero_o <= 1'b0;
      end
    end
  end
endmodule
